// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
//
// Holds the decoded instruction for one cycle and presents it to the EX-stage
// ALU. Source operands are forwarded combinationally from EX/MEM (highest
// priority) or MEM/WB. A load-use hazard against the instruction in decode is
// flagged on load_use_stall; this block never stalls itself.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   stall, flush                  hold / bubble the ID/EX register (flush wins)
//   id_*                          decoded fields from the ID stage
//   exmem_*, memwb_*              forwarding sources from later stages
//   alu_operand1/2, alu_opsel,
//   alu_shamt                     ALU inputs
//   ex_store_data                 forwarded rt value for stores
//   ex_rd, ex_valid, ex_*         registered destination and controls
//   load_use_stall                stall request to PC / IF-ID
module id_ex_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SEL_WIDTH  = 4,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [DATA_WIDTH-1:0] id_rs_data,
    input  logic [DATA_WIDTH-1:0] id_rt_data,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [SEL_WIDTH-1:0]  id_aluop,
    input  logic [4:0]            id_shamt,
    input  logic                  id_alusrc,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  id_memwrite,
    input  logic                  id_memtoreg,
    input  logic                  exmem_regwrite,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [DATA_WIDTH-1:0] exmem_result,
    input  logic                  memwb_regwrite,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [DATA_WIDTH-1:0] memwb_data,
    output logic [DATA_WIDTH-1:0] alu_operand1,
    output logic [DATA_WIDTH-1:0] alu_operand2,
    output logic [SEL_WIDTH-1:0]  alu_opsel,
    output logic [4:0]            alu_shamt,
    output logic [DATA_WIDTH-1:0] ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_valid,
    output logic                  ex_regwrite,
    output logic                  ex_memread,
    output logic                  ex_memwrite,
    output logic                  ex_memtoreg,
    output logic                  load_use_stall
);

    localparam logic [SEL_WIDTH-1:0] AluSll = SEL_WIDTH'(4'b0111);
    localparam logic [SEL_WIDTH-1:0] AluSrl = SEL_WIDTH'(4'b1000);

    logic                  valid_q,    valid_d;
    logic                  regwrite_q, regwrite_d;
    logic                  memread_q,  memread_d;
    logic                  memwrite_q, memwrite_d;
    logic                  memtoreg_q, memtoreg_d;
    logic                  alusrc_q,   alusrc_d;
    logic [SEL_WIDTH-1:0]  aluop_q,    aluop_d;
    logic [4:0]            shamt_q,    shamt_d;
    logic [REG_ADDR_W-1:0] rs_q,       rs_d;
    logic [REG_ADDR_W-1:0] rt_q,       rt_d;
    logic [REG_ADDR_W-1:0] rd_q,       rd_d;
    logic [DATA_WIDTH-1:0] rs_data_q,  rs_data_d;
    logic [DATA_WIDTH-1:0] rt_data_q,  rt_data_d;
    logic [DATA_WIDTH-1:0] imm_q,      imm_d;

    logic [DATA_WIDTH-1:0] fwd_rs;
    logic [DATA_WIDTH-1:0] fwd_rt;

    // Next state: flush > stall > load.
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        memtoreg_d = memtoreg_q;
        alusrc_d   = alusrc_q;
        aluop_d    = aluop_q;
        shamt_d    = shamt_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        rs_data_d  = rs_data_q;
        rt_data_d  = rt_data_q;
        imm_d      = imm_q;
        if (flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            alusrc_d   = 1'b0;
            aluop_d    = '0;
            shamt_d    = '0;
            rs_d       = '0;
            rt_d       = '0;
            rd_d       = '0;
            rs_data_d  = '0;
            rt_data_d  = '0;
            imm_d      = '0;
        end else if (!stall) begin
            valid_d    = id_valid;
            // Side-effecting controls are suppressed for empty decode slots.
            regwrite_d = id_regwrite & id_valid;
            memread_d  = id_memread & id_valid;
            memwrite_d = id_memwrite & id_valid;
            memtoreg_d = id_memtoreg;
            alusrc_d   = id_alusrc;
            aluop_d    = id_aluop;
            shamt_d    = id_shamt;
            rs_d       = id_rs;
            rt_d       = id_rt;
            rd_d       = id_rd;
            rs_data_d  = id_rs_data;
            rt_data_d  = id_rt_data;
            imm_d      = id_imm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            alusrc_q   <= 1'b0;
            aluop_q    <= '0;
            shamt_q    <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
            alusrc_q   <= alusrc_d;
            aluop_q    <= aluop_d;
            shamt_q    <= shamt_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            imm_q      <= imm_d;
        end
    end

    // Forwarding: register 0 is hard-wired and never forwarded; the younger
    // EX/MEM result beats MEM/WB.
    always_comb begin
        fwd_rs = rs_data_q;
        if (rs_q != '0) begin
            if (exmem_regwrite && exmem_rd == rs_q) begin
                fwd_rs = exmem_result;
            end else if (memwb_regwrite && memwb_rd == rs_q) begin
                fwd_rs = memwb_data;
            end
        end
        fwd_rt = rt_data_q;
        if (rt_q != '0) begin
            if (exmem_regwrite && exmem_rd == rt_q) begin
                fwd_rt = exmem_result;
            end else if (memwb_regwrite && memwb_rd == rt_q) begin
                fwd_rt = memwb_data;
            end
        end
    end

    always_comb begin
        // The ALU shifts operand1, so shifts route the rt value there.
        alu_operand1   = (aluop_q == AluSll || aluop_q == AluSrl) ? fwd_rt : fwd_rs;
        alu_operand2   = alusrc_q ? imm_q : fwd_rt;
        alu_opsel      = aluop_q;
        alu_shamt      = shamt_q;
        ex_store_data  = fwd_rt;
        ex_rd          = rd_q;
        ex_valid       = valid_q;
        ex_regwrite    = regwrite_q;
        ex_memread     = memread_q;
        ex_memwrite    = memwrite_q;
        ex_memtoreg    = memtoreg_q;
        load_use_stall = valid_q && memread_q && (rd_q != '0) && id_valid &&
                         ((rd_q == id_rs) || (rd_q == id_rt));
    end

endmodule
